system_ram_copy_master: RTL

- Avalon-MM master that copies a block of 32-bit words from one word address to another inside the on-chip RAM.
- Drives the RAM slave port directly: word addressing, fixed read latency, no waitrequest.
- Sits beside the CPU on the system bus; software programs src/dst/len, pulses start, then waits for done.

---
 rtl/system_ram_copy_master.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/system_ram_copy_master.sv
// system_ram_copy_master
// Avalon-MM master that copies a block of 32-bit words inside the on-chip RAM.
// Software programs src_addr/dst_addr/len and pulses start. The block then issues
// one read, waits READ_LATENCY cycles, and issues one write per word, in
// ascending address order. Both pointers wrap modulo 2^ADDR_W. done pulses for
// one cycle when the copy completes.
// Optional feature: define SYSTEM_RAM_COPY_CHECKSUM_EN to build a running 32-bit
// sum of the copied words on checksum. When it is not defined, checksum is tied to 0.
// Ports:
//   clk, reset_n                - clock and asynchronous active-low reset
//   start, src_addr, dst_addr, len - copy request; sampled only when idle
//   busy, done, checksum        - status outputs (registered)
//   m_address, m_byteenable, m_chipselect, m_write, m_writedata - RAM master (registered)
//   m_readdata                  - RAM read data
module system_ram_copy_master #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned LEN_W        = 11,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [31:0]       checksum,
    output logic [ADDR_W-1:0] m_address,
    output logic [3:0]        m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    input  logic [31:0]       m_readdata
);

    localparam int unsigned WAIT_W = 2;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_FIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              busy_d, done_d, cs_d, wr_d;
    logic [3:0]        be_d;
    logic [ADDR_W-1:0] addr_d;
    // m_writedata doubles as the captured read word (data_reg).
    logic [31:0]       wdata_d;
`ifdef SYSTEM_RAM_COPY_CHECKSUM_EN
    logic [31:0]       csum_q, csum_d;
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            src_ptr_q    <= '0;
            dst_ptr_q    <= '0;
            remaining_q  <= '0;
            wait_cnt_q   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            m_chipselect <= 1'b0;
            m_write      <= 1'b0;
            m_byteenable <= 4'h0;
            m_address    <= '0;
            m_writedata  <= '0;
`ifdef SYSTEM_RAM_COPY_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            remaining_q  <= remaining_d;
            wait_cnt_q   <= wait_cnt_d;
            busy         <= busy_d;
            done         <= done_d;
            m_chipselect <= cs_d;
            m_write      <= wr_d;
            m_byteenable <= be_d;
            m_address    <= addr_d;
            m_writedata  <= wdata_d;
`ifdef SYSTEM_RAM_COPY_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    // Next state. Each output value is computed for the state being entered,
    // so the registered outputs line up with the state they belong to.
    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        remaining_d = remaining_q;
        wait_cnt_d  = wait_cnt_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        cs_d        = 1'b0;
        wr_d        = 1'b0;
        be_d        = 4'h0;
        addr_d      = m_address;
        wdata_d     = m_writedata;
`ifdef SYSTEM_RAM_COPY_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_ptr_d   = src_addr;
                    dst_ptr_d   = dst_addr;
                    remaining_d = len;
`ifdef SYSTEM_RAM_COPY_CHECKSUM_EN
                    csum_d      = '0;
`endif
                    if (len != '0) begin
                        state_d = S_RD;
                        busy_d  = 1'b1;
                        cs_d    = 1'b1;
                        be_d    = 4'hF;
                        addr_d  = src_addr;
                    end else begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            S_RD: begin
                // Source pointer advances as soon as its read has been issued.
                state_d    = S_WAIT;
                busy_d     = 1'b1;
                wait_cnt_d = '0;
                src_ptr_d  = src_ptr_q + ADDR_W'(1);
            end
            S_WAIT: begin
                busy_d = 1'b1;
                if (wait_cnt_q == WAIT_W'(READ_LATENCY - 1)) begin
                    state_d = S_WR;
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                    be_d    = 4'hF;
                    addr_d  = dst_ptr_q;
                    wdata_d = m_readdata;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_WR: begin
                dst_ptr_d   = dst_ptr_q + ADDR_W'(1);
                remaining_d = remaining_q - LEN_W'(1);
`ifdef SYSTEM_RAM_COPY_CHECKSUM_EN
                csum_d      = csum_q + m_writedata;
`endif
                if (remaining_q == LEN_W'(1)) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_RD;
                    busy_d  = 1'b1;
                    cs_d    = 1'b1;
                    be_d    = 4'hF;
                    addr_d  = src_ptr_q;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef SYSTEM_RAM_COPY_CHECKSUM_EN
    assign checksum = csum_q;
`else
    assign checksum = 32'h0;
`endif

endmodule
